// File: rtl/fdtd_buf_wb_ctrl_pkg.sv
// fdtd_pkg: shared types and constants for the FDTD buffer write-back engine
//   wb_state_e  write-back FSM states
//   wb_job_e    job kinds; the value is also the bit index of the job's pending flag
//   WORD_BYTES  byte stride of one data-memory word
package fdtd_pkg;
    typedef enum logic [2:0] {IDLE, RD, LAT, REQ, DONE} wb_state_e;
    typedef enum logic [1:0] {JOB_HY, JOB_EZ, JOB_SRC} wb_job_e;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/fdtd_buf_wb_ctrl_if.sv
// fdtd_buf_wb_ctrl_if: ram_buffer read port plus data-memory req/gnt write port
//   master  write-back engine: drives buffer reads and memory writes
//   slave   Hy/Ez ram_buffers and the data-memory arbiter
interface fdtd_buf_wb_ctrl_if #(
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_DATA_WIDTH   = 16,
    parameter int MEM_ADDR_WIDTH    = 32
);
    logic                         rd_Hy_buf_en_o;
    logic                         rd_Ez_buf_en_o;
    logic [BUFFER_ADDR_WIDTH-1:0] rd_buf_addr_o;
    logic [FDTD_DATA_WIDTH-1:0]   rd_Hy_buf_data_i;
    logic [FDTD_DATA_WIDTH-1:0]   rd_Ez_buf_data_i;
    logic                         mem_req_o;
    logic                         mem_gnt_i;
    logic                         mem_we_o;
    logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o;
    logic [31:0]                  mem_wdata_o;
    modport master (
        output rd_Hy_buf_en_o, rd_Ez_buf_en_o, rd_buf_addr_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  rd_Hy_buf_data_i, rd_Ez_buf_data_i, mem_gnt_i
    );
    modport slave (
        input  rd_Hy_buf_en_o, rd_Ez_buf_en_o, rd_buf_addr_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output rd_Hy_buf_data_i, rd_Ez_buf_data_i, mem_gnt_i
    );
endinterface

// File: rtl/fdtd_buf_wb_ctrl_edge_pend.sv
// fdtd_start_edge_pend: falling-edge detect on the three start lines with sticky pending flags
//   CLK, RST_N  clock, async active-low reset
//   start_i     {src, Ez, Hy} start lines
//   clr_i       one-hot clear from the FSM when a job leaves IDLE
//   pend_o      pending flags, same bit order
module fdtd_start_edge_pend (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] start_i,
    input  logic [2:0] clr_i,
    output logic [2:0] pend_o
);
    logic [2:0] prev;
    // a fresh edge wins over a same-cycle clear so it is never lost
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            prev   <= '0;
            pend_o <= '0;
        end else begin
            prev   <= start_i;
            pend_o <= (pend_o & ~clr_i) | (prev & ~start_i);
        end
endmodule

// File: rtl/fdtd_buf_wb_ctrl.sv
// fdtd_buf_wb_ctrl: copies a finished Hy/Ez ram_buffer (or the Ez source word) to data memory
//   CLK, RST_N         clock, async active-low reset
//   buffer_size_i      last element index of a pass (low BUFFER_ADDR_WIDTH bits used)
//   hy/ez_base_addr_i  byte base addresses of the Hy and Ez arrays
//   wrt_*_start_i      calculation-controller lines; a falling edge queues a job
//   bus                ram_buffer read port and data-memory write port (master side)
//   busy_o, wb_done_o  job in progress / one-cycle end-of-job pulse
module fdtd_buf_wb_ctrl
    import fdtd_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_DATA_WIDTH   = 16,
    parameter int MEM_ADDR_WIDTH    = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [FDTD_DATA_WIDTH-1:0] buffer_size_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  hy_base_addr_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  ez_base_addr_i,
    input  logic                       wrt_Hy_start_i,
    input  logic                       wrt_Ez_start_i,
    input  logic                       wrt_src_start_i,
    fdtd_buf_wb_ctrl_if.master         bus,
    output logic                       busy_o,
    output logic                       wb_done_o
);
    // one extra index bit so a full 2^BUFFER_ADDR_WIDTH-word pass ends without wrapping
    localparam int IW = BUFFER_ADDR_WIDTH + 1;
    wb_state_e                  state;
    wb_job_e                    job;
    wb_job_e                    nxt_job;
    logic [2:0]                 pend;
    logic [2:0]                 clr;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              last;
    logic [MEM_ADDR_WIDTH-1:0]  base;
    logic [FDTD_DATA_WIDTH-1:0] rd_word;
    logic                       unused_size;

    assign unused_size = ^buffer_size_i[FDTD_DATA_WIDTH-1:BUFFER_ADDR_WIDTH];
    assign busy_o      = (state != IDLE);

    fdtd_start_edge_pend u_pend (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start_i({wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i}),
        .clr_i  (clr),
        .pend_o (pend)
    );

    always_comb begin
        nxt_job = pend[JOB_HY] ? JOB_HY : pend[JOB_EZ] ? JOB_EZ : JOB_SRC;
        clr     = (state == IDLE && |pend) ? 3'b001 << nxt_job : 3'b000;
        rd_word = (job == JOB_HY) ? bus.rd_Hy_buf_data_i : bus.rd_Ez_buf_data_i;
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state              <= IDLE;
            job                <= JOB_HY;
            idx                <= '0;
            last               <= '0;
            base               <= '0;
            bus.rd_Hy_buf_en_o <= 1'b0;
            bus.rd_Ez_buf_en_o <= 1'b0;
            bus.rd_buf_addr_o  <= '0;
            bus.mem_req_o      <= 1'b0;
            bus.mem_we_o       <= 1'b0;
            bus.mem_addr_o     <= '0;
            bus.mem_wdata_o    <= '0;
            wb_done_o          <= 1'b0;
        end else begin
            bus.rd_Hy_buf_en_o <= 1'b0;
            bus.rd_Ez_buf_en_o <= 1'b0;
            wb_done_o          <= 1'b0;
            case (state)
                IDLE: if (|pend) begin
                    job                <= nxt_job;
                    idx                <= '0;
                    // the source job is a single word: Ez index 0
                    last               <= (nxt_job == JOB_SRC) ? '0 : IW'(buffer_size_i[BUFFER_ADDR_WIDTH-1:0]);
                    base               <= (nxt_job == JOB_HY) ? hy_base_addr_i : ez_base_addr_i;
                    bus.rd_Hy_buf_en_o <= (nxt_job == JOB_HY);
                    bus.rd_Ez_buf_en_o <= (nxt_job != JOB_HY);
                    bus.rd_buf_addr_o  <= '0;
                    state              <= RD;
                end
                RD: state <= LAT;
                LAT: begin
                    bus.mem_wdata_o <= {{(32-FDTD_DATA_WIDTH){rd_word[FDTD_DATA_WIDTH-1]}}, rd_word};
                    bus.mem_addr_o  <= base + MEM_ADDR_WIDTH'(idx) * MEM_ADDR_WIDTH'(WORD_BYTES);
                    bus.mem_req_o   <= 1'b1;
                    bus.mem_we_o    <= 1'b1;
                    state           <= REQ;
                end
                REQ: if (bus.mem_gnt_i) begin
                    bus.mem_req_o <= 1'b0;
                    bus.mem_we_o  <= 1'b0;
                    if (idx == last) begin
                        wb_done_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx                <= idx + 1'b1;
                        bus.rd_Hy_buf_en_o <= (job == JOB_HY);
                        bus.rd_Ez_buf_en_o <= (job != JOB_HY);
                        bus.rd_buf_addr_o  <= BUFFER_ADDR_WIDTH'(idx + 1'b1);
                        state              <= RD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_fdtd_buf_wb_ctrl.sv
// tb_fdtd_buf_wb_ctrl: self-checking bench for fdtd_buf_wb_ctrl against a queue-based write model
module tb_fdtd_buf_wb_ctrl;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] buffer_size_i = '0;
    logic [31:0] hy_base_addr_i = '0;
    logic [31:0] ez_base_addr_i = '0;
    logic        wrt_Hy_start_i = 1'b0;
    logic        wrt_Ez_start_i = 1'b0;
    logic        wrt_src_start_i = 1'b0;
    logic        busy_o;
    logic        wb_done_o;
    logic [15:0] hy_mem [64];
    logic [15:0] ez_mem [64];
    wr_t         wr_q [$];
    wr_t         exp_q [$];
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    fdtd_buf_wb_ctrl_if bus ();

    fdtd_buf_wb_ctrl dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .buffer_size_i  (buffer_size_i),
        .hy_base_addr_i (hy_base_addr_i),
        .ez_base_addr_i (ez_base_addr_i),
        .wrt_Hy_start_i (wrt_Hy_start_i),
        .wrt_Ez_start_i (wrt_Ez_start_i),
        .wrt_src_start_i(wrt_src_start_i),
        .bus            (bus),
        .busy_o         (busy_o),
        .wb_done_o      (wb_done_o)
    );

    always #5 CLK = ~CLK;

    // synchronous ram_buffers, memory write monitor, done-pulse counter
    always @(posedge CLK) begin
        if (bus.rd_Hy_buf_en_o) bus.rd_Hy_buf_data_i <= hy_mem[bus.rd_buf_addr_o];
        if (bus.rd_Ez_buf_en_o) bus.rd_Ez_buf_data_i <= ez_mem[bus.rd_buf_addr_o];
        if (bus.mem_req_o && bus.mem_gnt_i) wr_q.push_back({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_we_o});
        if (wb_done_o) done_cnt++;
    end

    function automatic void exp_add(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        e.we = 1'b1;
        exp_q.push_back(e);
    endfunction

    // kind 0=Hy, 1=Ez, 2=source; each word lands at base + 4*i, sign-extended
    function automatic void model(input int kind, input int size, input logic [31:0] base);
        for (int i = 0; i <= (kind == 2 ? 0 : size); i++) begin
            logic [15:0] w;
            logic signed [31:0] s;
            w = (kind == 0) ? hy_mem[i] : ez_mem[i];
            s = $signed(w);
            exp_add(base + 32'(i * 4), s);
        end
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            hy_mem[i] = 16'($urandom);
            ez_mem[i] = 16'($urandom);
        end
    endtask

    // raise the selected lines {src,Ez,Hy} for two cycles, then drop them; the next posedge samples the fall
    task automatic trig(input logic [2:0] m);
        {wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i} = m;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        {wrt_src_start_i, wrt_Ez_start_i, wrt_Hy_start_i} = 3'b000;
    endtask

    task automatic wait_done(input int need, input int budget, input bit rg, output int cyc);
        int seen = 0;
        cyc = 0;
        while (seen < need && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (wb_done_o) seen++;
            if (rg) bus.mem_gnt_i = 1'($urandom_range(0, 1));
        end
        if (seen < need) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d of %0d done pulses after %0d cycles", seen, need, cyc);
        end
    endtask

    task automatic test_reset;
        #2 RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.rd_Hy_buf_en_o, bus.rd_Ez_buf_en_o, busy_o, wb_done_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got req/we/rdh/rde/busy/done=%b expected 000000",
                     {bus.mem_req_o, bus.mem_we_o, bus.rd_Hy_buf_en_o, bus.rd_Ez_buf_en_o, busy_o, wb_done_o});
        end
        n_cmp++;
        if ({bus.mem_addr_o, bus.mem_wdata_o, bus.rd_buf_addr_o} !== 70'b0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdaddr=%h expected 0", bus.mem_addr_o, bus.mem_wdata_o, bus.rd_buf_addr_o);
        end
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || wr_q.size() !== 0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b writes=%0d expected 0 0", busy_o, wr_q.size());
        end
    endtask

    task automatic test_hy_basic;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'd3;
        hy_base_addr_i = 32'h0010_0000;
        hy_mem[0] = 16'h0001;
        hy_mem[1] = 16'h8000;
        hy_mem[2] = 16'h7FFF;
        hy_mem[3] = 16'hFFFF;
        exp_add(32'h0010_0000, 32'h0000_0001);
        exp_add(32'h0010_0004, 32'hFFFF_8000);
        exp_add(32'h0010_0008, 32'h0000_7FFF);
        exp_add(32'h0010_000C, 32'hFFFF_FFFF);
        trig(3'b001);
        @(posedge CLK);
        #1;
        wait_done(1, 40, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 13) begin
            n_bad++;
            $display("FAIL hy_basic latency: got %0d cycles expected 13", cyc);
        end
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== exp_q.size() || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL hy_basic count: got %0d writes %0d done expected %0d 1", wr_q.size() - n0, done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL hy_basic write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                         i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_gnt_stall;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        bit found = 1'b0;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'd3;
        hy_base_addr_i = 32'h0010_0000;
        fill_random(4);
        model(0, 3, hy_base_addr_i);
        trig(3'b001);
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge CLK);
            #1;
            found = bus.mem_req_o && bus.mem_addr_o == exp_q[1].a;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL gnt_stall reach: word 1 request not seen, expected addr %h", exp_q[1].a);
        end
        bus.mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== exp_q[1].a || bus.mem_wdata_o !== exp_q[1].d) begin
                n_bad++;
                $display("FAIL gnt_stall hold %0d: got req=%b we=%b a=%h d=%h expected 1 1 %h %h",
                         i, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, exp_q[1].a, exp_q[1].d);
            end
        end
        bus.mem_gnt_i = 1'b1;
        wait_done(1, 40, 1'b0, cyc);
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== exp_q.size() || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL gnt_stall count: got %0d writes %0d done expected %0d 1", wr_q.size() - n0, done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL gnt_stall write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                         i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_src;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'($urandom_range(1, 63));
        ez_base_addr_i = 32'h0020_0000;
        ez_mem[0] = 16'hFFFE;
        exp_add(32'h0020_0000, 32'hFFFF_FFFE);
        trig(3'b100);
        wait_done(1, 30, 1'b0, cyc);
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== 1 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL src count: got %0d writes %0d done expected 1 1", wr_q.size() - n0, done_cnt - d0);
        end
        n_cmp++;
        if (wr_q.size() > n0 && wr_q[n0] !== exp_q[0]) begin
            n_bad++;
            $display("FAIL src write: got a=%h d=%h we=%b expected a=%h d=%h we=1", wr_q[n0].a, wr_q[n0].d, wr_q[n0].we, exp_q[0].a, exp_q[0].d);
        end
    endtask

    task automatic test_simultaneous;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        int size = $urandom_range(1, 6);
        exp_q.delete();
        buffer_size_i = 16'(size);
        hy_base_addr_i = $urandom & 32'hFFFF_FFFC;
        ez_base_addr_i = $urandom & 32'hFFFF_FFFC;
        fill_random(size + 1);
        model(0, size, hy_base_addr_i);
        model(1, size, ez_base_addr_i);
        trig(3'b011);
        wait_done(2, 400, 1'b1, cyc);
        bus.mem_gnt_i = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== exp_q.size() || done_cnt - d0 !== 2) begin
            n_bad++;
            $display("FAIL simul count: got %0d writes %0d done expected %0d 2", wr_q.size() - n0, done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL simul write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                         i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    // two Hy edges while an Ez job runs merge into one queued Hy job
    task automatic test_merge;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'd7;
        hy_base_addr_i = 32'h0030_0000;
        ez_base_addr_i = 32'h0040_0000;
        fill_random(8);
        model(1, 7, ez_base_addr_i);
        model(0, 7, hy_base_addr_i);
        trig(3'b010);
        trig(3'b001);
        trig(3'b001);
        wait_done(2, 200, 1'b0, cyc);
        repeat (40) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== exp_q.size() || done_cnt - d0 !== 2) begin
            n_bad++;
            $display("FAIL merge count: got %0d writes %0d done expected %0d 2", wr_q.size() - n0, done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL merge write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                         i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_full_ez;
        int n0 = wr_q.size();
        int d0 = done_cnt;
        int cyc;
        logic [31:0] base = $urandom;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'd63;
        ez_base_addr_i = base;
        fill_random(64);
        model(1, 63, base);
        trig(3'b010);
        wait_done(1, 300, 1'b0, cyc);
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() - n0 !== 64 || done_cnt - d0 !== 1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ez count: got %0d writes %0d done busy=%b expected 64 1 0", wr_q.size() - n0, done_cnt - d0, busy_o);
        end
        n_cmp++;
        if (wr_q.size() >= n0 + 64 && wr_q[n0+63].a !== base + 32'h0000_00FC) begin
            n_bad++;
            $display("FAIL full_ez last_addr: got %h expected %h", wr_q[n0+63].a, base + 32'h0000_00FC);
        end
        for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[n0+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL full_ez write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                         i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    // random job kind/size/grant; size and bases are scrambled once the job has started
    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            int n0 = wr_q.size();
            int d0 = done_cnt;
            int cyc;
            int kind = $urandom_range(0, 2);
            int size = $urandom_range(0, 15);
            exp_q.delete();
            bus.mem_gnt_i = 1'b1;
            buffer_size_i = {10'($urandom), 6'(size)};
            hy_base_addr_i = $urandom;
            ez_base_addr_i = $urandom;
            fill_random(size + 1);
            model(kind, size, kind == 0 ? hy_base_addr_i : ez_base_addr_i);
            trig(3'b001 << kind);
            @(posedge CLK);
            @(posedge CLK);
            #1;
            buffer_size_i = 16'($urandom);
            hy_base_addr_i = $urandom;
            ez_base_addr_i = $urandom;
            wait_done(1, 400, 1'b1, cyc);
            bus.mem_gnt_i = 1'b1;
            repeat (3) @(posedge CLK);
            #1;
            n_cmp++;
            if (wr_q.size() - n0 !== exp_q.size() || done_cnt - d0 !== 1) begin
                n_bad++;
                $display("FAIL random[%0d] count: got %0d writes %0d done expected %0d 1", it, wr_q.size() - n0, done_cnt - d0, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && n0 + i < wr_q.size(); i++) begin
                n_cmp++;
                if (wr_q[n0+i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL random[%0d] write %0d: got a=%h d=%h we=%b expected a=%h d=%h we=1",
                             it, i, wr_q[n0+i].a, wr_q[n0+i].d, wr_q[n0+i].we, exp_q[i].a, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        int d0;
        bit found = 1'b0;
        exp_q.delete();
        bus.mem_gnt_i = 1'b1;
        buffer_size_i = 16'd3;
        hy_base_addr_i = 32'h0010_0000;
        fill_random(4);
        model(0, 3, hy_base_addr_i);
        trig(3'b001);
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge CLK);
            #1;
            found = bus.mem_req_o && bus.mem_addr_o == exp_q[2].a;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL reset_mid reach: word 2 request not seen, expected addr %h", exp_q[2].a);
        end
        #2 RST_N = 1'b0;
        #1;
        n0 = wr_q.size();
        d0 = done_cnt;
        n_cmp++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.rd_Hy_buf_en_o, bus.rd_Ez_buf_en_o, busy_o, wb_done_o} !== 6'b0 ||
            {bus.mem_addr_o, bus.mem_wdata_o, bus.rd_buf_addr_o} !== 70'b0) begin
            n_bad++;
            $display("FAIL reset_mid outputs: got ctrl=%b addr=%h wdata=%h rdaddr=%h expected all 0",
                     {bus.mem_req_o, bus.mem_we_o, bus.rd_Hy_buf_en_o, bus.rd_Ez_buf_en_o, busy_o, wb_done_o},
                     bus.mem_addr_o, bus.mem_wdata_o, bus.rd_buf_addr_o);
        end
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (30) @(posedge CLK);
        #1;
        n_cmp++;
        if (wr_q.size() !== n0 || done_cnt !== d0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid after: got %0d writes %0d done busy=%b expected 0 0 0", wr_q.size() - n0, done_cnt - d0, busy_o);
        end
    endtask

    initial begin
        bus.mem_gnt_i = 1'b1;
        test_reset();
        test_hy_basic();
        test_gnt_stall();
        test_src();
        test_simultaneous();
        test_merge();
        test_full_ez();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
